// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the common_fifo reader-side stream adapter.
//   buf_state_e : coarse occupancy of the 3-entry output buffer (assertions)
//   lsize_f     : width of a beat counter able to hold 0..pkt_len
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_PART,
        BUF_FULL
    } buf_state_e;

    // Never returns less than 1 so PKT_LEN=1 still yields a legal vector.
    function automatic int lsize_f(input int pkt_len);
        return ($clog2(pkt_len + 1) < 1) ? 1 : $clog2(pkt_len + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_skid3.sv
// 3-entry circular output buffer with push/pop and occupancy count.
//   clock, rst_n : clock and asynchronous active-low reset
//   push, push_data : write one word at the write pointer
//   pop          : retire the word at the read pointer
//   data         : word at the read pointer
//   count        : occupancy 0..3
module fifo_rd_skid3
    import fifo_stream_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output logic [DSIZE-1:0] data,
    output logic [1:0]       count
);

    logic [DSIZE-1:0] mem [0:2];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    buf_state_e       state;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: data is only observed when count != 0.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign data = mem[rd_ptr];

    always_comb begin
        state = BUF_PART;
        if (count == 2'd0)      state = BUF_EMPTY;
        else if (count == 2'd3) state = BUF_FULL;
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
        !(state == BUF_FULL && push && !pop));
    a_no_underflow: assert property (@(posedge clock) disable iff (!rst_n)
        !(state == BUF_EMPTY && pop));

endmodule

// File: rtl/fifo_rd_stream.sv
// Reader-side adapter: drains a common_fifo (rd_en/empty/rdata) into a
// valid/ready stream and frames it into PKT_LEN-beat packets.
//   clock, rst_n           : shared clock, asynchronous active-low reset
//   fifo_rdata, fifo_empty : common_fifo read side inputs
//   fifo_rd_en             : read strobe, never high while fifo_empty
//   out_data/valid/ready   : output stream handshake
//   out_last               : final beat of each packet
//   beat_cnt, pkt_cnt      : beats sent in current packet, packets completed
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int DSIZE   = 8,
    parameter int PKT_LEN = 16,
    parameter int LSIZE   = lsize_f(PKT_LEN)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [LSIZE-1:0] beat_cnt,
    output logic [15:0]      pkt_cnt
);

    localparam logic [LSIZE-1:0] LAST_BEAT = LSIZE'(PKT_LEN - 1);

    logic       inflight;
    logic [1:0] buf_cnt;
    logic [2:0] level;
    logic       pop;

    // Reserve a buffer slot for the word in flight, so issue never
    // depends on out_ready and the buffer cannot overflow.
    assign level      = {1'b0, buf_cnt} + {2'b00, inflight};
    assign fifo_rd_en = rst_n && !fifo_empty && (level < 3'd3);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) inflight <= 1'b0;
        else        inflight <= fifo_rd_en;
    end

    fifo_rd_skid3 #(.DSIZE(DSIZE)) u_skid (
        .clock     (clock),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_rdata),
        .pop       (pop),
        .data      (out_data),
        .count     (buf_cnt)
    );

    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (beat_cnt == LAST_BEAT);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (pop) begin
            if (out_last) begin
                beat_cnt <= '0;
                pkt_cnt  <= pkt_cnt + 16'd1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (PKT_LEN=16 and PKT_LEN=1), each
// fed by a depth-4 FIFO model. Written words go to a scoreboard; a monitor
// checks every beat against it and the packet framing rules.
module tb_fifo_rd_stream;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_n;
    logic wr_en [2];
    logic out_ready [2];

    logic [7:0] f_mem [2][4];
    logic [1:0] f_wp [2]    = '{default: '0};
    logic [1:0] f_rp [2]    = '{default: '0};
    logic [2:0] f_cnt [2]   = '{default: '0};
    logic [7:0] f_rdata [2] = '{default: '0};
    logic [7:0] next_val [2] = '{default: '0};
    int         acc [2]      = '{default: 0};

    logic [7:0] exp_mem [2][4096];
    int         exp_tail [2] = '{default: 0};
    int         exp_head [2] = '{default: 0};
    int         delivered [2] = '{default: 0};

    logic       rd_en [2];
    logic       empty [2];
    logic       valid [2];
    logic       last [2];
    logic [7:0] odata [2];
    int         beat [2];
    int         pkt [2];
    logic [4:0] beat_cnt0;
    logic [0:0] beat_cnt1;
    logic [15:0] pkt0, pkt1;

    int total = 0;
    int bad   = 0;
    logic one_chk = 1'b0, bp_chk = 1'b0, fin_chk = 1'b0, timeout = 1'b0;

    assign empty[0] = (f_cnt[0] == 3'd0);
    assign empty[1] = (f_cnt[1] == 3'd0);
    assign beat[0]  = int'(beat_cnt0);
    assign beat[1]  = int'(beat_cnt1);
    assign pkt[0]   = int'(pkt0);
    assign pkt[1]   = int'(pkt1);

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(16)) dut (
        .clock(clock), .rst_n(rst_n), .fifo_rdata(f_rdata[0]), .fifo_empty(empty[0]),
        .fifo_rd_en(rd_en[0]), .out_data(odata[0]), .out_valid(valid[0]),
        .out_ready(out_ready[0]), .out_last(last[0]), .beat_cnt(beat_cnt0), .pkt_cnt(pkt0)
    );

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(1)) dut1 (
        .clock(clock), .rst_n(rst_n), .fifo_rdata(f_rdata[1]), .fifo_empty(empty[1]),
        .fifo_rd_en(rd_en[1]), .out_data(odata[1]), .out_valid(valid[1]),
        .out_ready(out_ready[1]), .out_last(last[1]), .beat_cnt(beat_cnt1), .pkt_cnt(pkt1)
    );

    // Depth-4 FIFO model; every accepted write is also queued as expected output.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i] && f_cnt[i] != 3'd0) begin
                f_rdata[i] <= f_mem[i][f_rp[i]];
                f_rp[i]    <= f_rp[i] + 2'd1;
            end
            if (wr_en[i] && f_cnt[i] != 3'd4) begin
                f_mem[i][f_wp[i]] <= next_val[i];
                f_wp[i]           <= f_wp[i] + 2'd1;
                next_val[i]       <= next_val[i] + 8'd1;
                exp_mem[i][exp_tail[i] % 4096] <= next_val[i];
                exp_tail[i]       <= exp_tail[i] + 1;
            end
            f_cnt[i] <= f_cnt[i] + 3'(wr_en[i] && f_cnt[i] != 3'd4)
                                 - 3'(rd_en[i] && f_cnt[i] != 3'd0);
            if (!rst_n)                             acc[i] <= 0;
            else if (rd_en[i] && f_cnt[i] != 3'd0)  acc[i] <= acc[i] + 1;
        end
    end

    task automatic chk(input bit ok, input string name, input int inst, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s[%0d] actual=%0d required=%0d", name, inst, act, req);
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        logic       prev_empty [2] = '{1'b1, 1'b1};
        logic       hold [2]       = '{1'b0, 1'b0};
        logic [7:0] hold_data [2];
        logic       hold_last [2];
        int         lat [2] = '{0, 0};
        int         plen, pend, d;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                plen = (i == 0) ? 16 : 1;
                if (!rst_n) begin
                    chk(!valid[i], "rst_valid", i, int'(valid[i]), 0);
                    chk(!last[i], "rst_last", i, int'(last[i]), 0);
                    chk(!rd_en[i], "rst_rd_en", i, int'(rd_en[i]), 0);
                    chk(beat[i] == 0, "rst_beat_cnt", i, beat[i], 0);
                    chk(pkt[i] == 0, "rst_pkt_cnt", i, pkt[i], 0);
                    // Words still inside the FIFO survive; anything already read is lost.
                    delivered[i]  = 0;
                    exp_head[i]   = exp_tail[i] - int'(f_cnt[i]);
                    hold[i]       = 1'b0;
                    lat[i]        = 0;
                    prev_empty[i] = empty[i];
                end else begin
                    d    = delivered[i];
                    pend = acc[i] - d;
                    chk(!(rd_en[i] && empty[i]), "rd_en_while_empty", i, int'(rd_en[i]), 0);
                    chk(pend <= 3, "held_words", i, pend, 3);
                    chk(beat[i] == d % plen, "beat_cnt", i, beat[i], d % plen);
                    chk(pkt[i] == (d / plen) % 65536, "pkt_cnt", i, pkt[i], (d / plen) % 65536);
                    chk(last[i] == (valid[i] && (d % plen == plen - 1)), "out_last", i,
                        int'(last[i]), int'(valid[i] && (d % plen == plen - 1)));
                    if (hold[i]) begin
                        chk(valid[i], "stall_valid", i, int'(valid[i]), 1);
                        chk(odata[i] == hold_data[i], "stall_data", i, int'(odata[i]), int'(hold_data[i]));
                        chk(last[i] == hold_last[i], "stall_last", i, int'(last[i]), int'(hold_last[i]));
                    end
                    if (lat[i] == 2) chk(!valid[i], "latency_early", i, int'(valid[i]), 0);
                    if (lat[i] == 1) chk(valid[i], "latency_2cyc", i, int'(valid[i]), 1);
                    if (lat[i] > 0) lat[i]--;
                    if (prev_empty[i] && !empty[i] && pend == 0) lat[i] = 2;
                    if (i == 0 && bp_chk) begin
                        chk(pend == 3, "bp_reads", i, pend, 3);
                        chk(f_cnt[i] == 3'd1, "bp_fifo_left", i, int'(f_cnt[i]), 1);
                    end
                    if (i == 0 && one_chk)
                        chk(acc[i] == 1 && d == 1, "single_word", i, acc[i] * 100 + d, 101);
                    if (i == 0 && timeout) chk(1'b0, "wait_beats", i, d, 5);
                    if (fin_chk) chk(exp_head[i] == exp_tail[i], "drained", i, exp_head[i], exp_tail[i]);
                    if (valid[i]) begin
                        if (exp_head[i] == exp_tail[i]) begin
                            chk(1'b0, "spurious_beat", i, int'(odata[i]), -1);
                        end else begin
                            chk(odata[i] == exp_mem[i][exp_head[i] % 4096], "data_order", i,
                                int'(odata[i]), int'(exp_mem[i][exp_head[i] % 4096]));
                            if (out_ready[i]) begin
                                exp_head[i]++;
                                delivered[i]++;
                            end
                        end
                    end
                    hold[i]       = valid[i] && !out_ready[i];
                    hold_data[i]  = odata[i];
                    hold_last[i]  = last[i];
                    prev_empty[i] = empty[i];
                end
            end
        end
    end

    // Stimulus.
    initial begin
        rst_n = 1'b0;
        wr_en = '{1'b0, 1'b0};
        out_ready = '{1'b0, 1'b0};
        repeat (3) @(posedge clock);
        #2 rst_n = 1'b1;

        // Single word: fifo_empty rises right after the read; one beat only.
        @(posedge clock); #1 wr_en[0] = 1'b1;
        @(posedge clock); #1 wr_en[0] = 1'b0; out_ready[0] = 1'b1;
        repeat (8) @(posedge clock);
        #1 one_chk = 1'b1;
        @(posedge clock); #1 one_chk = 1'b0;

        // Backpressure: 4 words, consumer stalled.
        out_ready[0] = 1'b0; wr_en[0] = 1'b1;
        repeat (4) @(posedge clock);
        #1 wr_en[0] = 1'b0;
        repeat (10) @(posedge clock);
        #1 bp_chk = 1'b1;
        @(posedge clock); #1 bp_chk = 1'b0; out_ready[0] = 1'b1;
        repeat (10) @(posedge clock);

        // Stream-through: 64 words on PKT_LEN=16, 8 words on PKT_LEN=1.
        begin
            int base0, base1;
            base0 = exp_tail[0];
            base1 = exp_tail[1];
            #1 wr_en[0] = 1'b1; wr_en[1] = 1'b1; out_ready[1] = 1'b1;
            for (int c = 0; c < 300 && (wr_en[0] || wr_en[1]); c++) begin
                @(posedge clock); #1;
                if (exp_tail[0] - base0 >= 64) wr_en[0] = 1'b0;
                if (exp_tail[1] - base1 >= 8)  wr_en[1] = 1'b0;
            end
            wr_en[0] = 1'b0; wr_en[1] = 1'b0;
        end
        repeat (10) @(posedge clock);

        // Random traffic on both instances.
        repeat (2000) begin
            @(posedge clock); #1;
            for (int i = 0; i < 2; i++) begin
                wr_en[i]     = 1'($urandom % 2);
                out_ready[i] = 1'($urandom % 2);
            end
        end
        @(posedge clock); #1;
        wr_en = '{1'b0, 1'b0};
        out_ready = '{1'b1, 1'b1};
        repeat (12) @(posedge clock);

        // Clean reset, then reset again mid-packet with a read in flight.
        #2 rst_n = 1'b0;
        @(posedge clock); #2 rst_n = 1'b1;
        wr_en[0] = 1'b1;
        begin
            int c;
            for (c = 0; c < 60 && delivered[0] < 5; c++) @(posedge clock);
            if (delivered[0] < 5) begin
                #1 timeout = 1'b1;
                @(posedge clock); #1 timeout = 1'b0;
            end
        end
        #2 rst_n = 1'b0; wr_en[0] = 1'b0;
        @(posedge clock); #2 rst_n = 1'b1;
        wr_en[0] = 1'b1;
        repeat (20) @(posedge clock);
        #1 wr_en[0] = 1'b0;
        repeat (12) @(posedge clock);
        #1 fin_chk = 1'b1;
        @(posedge clock); #1 fin_chk = 1'b0;
        @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
